// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU issued from EX.
// Returns {remainder, quotient}; one quotient bit per clock.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // dvd_q shifts dividend bits out the top and quotient bits in the bottom
    always_comb begin
        partial  = {rem_q, dvd_q[WIDTH-1]};
        diff     = partial - {1'b0, dvs_q};
        quot_fix = qneg_q ? -dvd_q : dvd_q;
        rem_fix  = rneg_q ? -rem_q : rem_q;

        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = ready_q;

        unique case (state_q)
            S_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        dvd_d   = (signed_div_i && opdata1_i[WIDTH-1])
                                  ? -opdata1_i : opdata1_i;
                        dvs_d   = (signed_div_i && opdata2_i[WIDTH-1])
                                  ? -opdata2_i : opdata2_i;
                        qneg_d  = signed_div_i
                                  && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        rneg_d  = signed_div_i && opdata1_i[WIDTH-1];
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = S_ON;
                    end
                end
            end
            S_BYZERO: begin
                result_d = '0;
                ready_d  = 1'b0;
                state_d  = annul_i ? S_FREE : S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q != CW'(WIDTH)) begin
                    rem_d = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end
            end
            S_END: begin
                if (start_i) begin
                    ready_d = 1'b1;
                end else begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    state_d  = S_FREE;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = (state_q == S_BYZERO) || (state_q == S_ON);

endmodule

// File: tb/tb_div_seq.sv
// Randomized self-checking bench for div_seq against an
// arithmetic reference model (plain / and % operators).
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic sg,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] q;
        logic [63:0] r;
        if (b == 32'd0) return 64'd0;
        if (!sg) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = 64'(sa / sb);
        r  = 64'(sa % sb);
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op, scrambles operands after the accept edge, waits for
    // ready_o (bounded), captures result, then drops start for one edge.
    task automatic do_op(input logic sg, input logic [31:0] a,
                         input logic [31:0] b,
                         output logic [63:0] res, output int lat);
        signed_div_i = sg;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        lat          = -1;
        res          = 'x;
        tick();
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sg;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        res     = result_o;
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start_i = 1'b1;
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        repeat (3) tick();
        n_cmp++;
        if ({result_o, ready_o, busy_o} !== 66'd0) begin
            n_err++;
            $display("FAIL reset: got res=%h rdy=%b busy=%b want 0",
                     result_o, ready_o, busy_o);
        end
        start_i = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_divu_basic();
        logic        busy_first;
        logic        busy_last;
        logic        busy_after;
        int          lat;
        signed_div_i = 1'b0;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        lat = -1;
        busy_first = 1'b0;
        busy_last = 1'b0;
        busy_after = 1'b1;
        tick();
        opdata1_i = 32'hdead_beef;
        opdata2_i = 32'd3;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) busy_first = busy_o;
            if (k == 32) busy_last = busy_o;
            if (ready_o) begin
                lat = k;
                busy_after = busy_o;
                break;
            end
        end
        n_cmp++;
        if (lat !== 33) begin
            n_err++;
            $display("FAIL divu_lat: got %0d want 33", lat);
        end
        n_cmp++;
        if (result_o !== {32'd2, 32'd14}) begin
            n_err++;
            $display("FAIL divu_100_7: got %h want %h",
                     result_o, {32'd2, 32'd14});
        end
        n_cmp++;
        if ({busy_first, busy_last, busy_after} !== 3'b110) begin
            n_err++;
            $display("FAIL divu_busy: got %b want 110",
                     {busy_first, busy_last, busy_after});
        end
        start_i = 1'b0;
        tick();
        n_cmp++;
        if ({ready_o, result_o} !== 65'd0) begin
            n_err++;
            $display("FAIL divu_release: got rdy=%b res=%h want 0",
                     ready_o, result_o);
        end
    endtask

    task automatic test_signed();
        logic [63:0] res;
        int          lat;
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat);
        n_cmp++;
        if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || lat !== 33) begin
            n_err++;
            $display("FAIL div_m7_2: got %h lat %0d want %h lat 33",
                     res, lat, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        end
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, res, lat);
        n_cmp++;
        if (res !== {32'd1, 32'hFFFF_FFFD}) begin
            n_err++;
            $display("FAIL div_7_m2: got %h want %h",
                     res, {32'd1, 32'hFFFF_FFFD});
        end
    endtask

    task automatic test_byzero();
        logic [63:0] res;
        int          lat;
        do_op(1'b0, 32'd5, 32'd0, res, lat);
        n_cmp++;
        if (lat !== 2 || res !== 64'd0) begin
            n_err++;
            $display("FAIL byzero: got lat %0d res %h want lat 2 res 0",
                     lat, res);
        end
        n_cmp++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL byzero_release: got rdy=%b busy=%b want 0 0",
                     ready_o, busy_o);
        end
    endtask

    task automatic test_hold_end();
        logic [63:0] res;
        logic        ok;
        int          lat;
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd33;
        start_i = 1'b1;
        lat = -1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        res = result_o;
        ok = (lat == 33);
        annul_i = 1'b1;
        repeat (3) begin
            tick();
            if (ready_o !== 1'b1 || result_o !== res) ok = 1'b0;
        end
        annul_i = 1'b0;
        n_cmp++;
        if (!ok || res !== {32'd10, 32'd30}) begin
            n_err++;
            $display("FAIL hold_end: got %h ok=%b want %h stable",
                     res, ok, {32'd10, 32'd30});
        end
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_annul();
        logic [63:0] res;
        logic        saw_ready;
        int          lat;
        signed_div_i = 1'b0;
        opdata1_i = 32'h1234_5678;
        opdata2_i = 32'd77;
        start_i = 1'b1;
        saw_ready = 1'b0;
        tick();
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (ready_o) saw_ready = 1'b1;
        end
        annul_i = 1'b1;
        tick();
        if (ready_o) saw_ready = 1'b1;
        annul_i = 1'b0;
        start_i = 1'b0;
        n_cmp++;
        if (saw_ready || busy_o !== 1'b0 || result_o !== 64'd0) begin
            n_err++;
            $display("FAIL annul: got rdy_seen=%b busy=%b res=%h want 0 0 0",
                     saw_ready, busy_o, result_o);
        end
        do_op(1'b0, 32'd9, 32'd3, res, lat);
        n_cmp++;
        if (res !== {32'd0, 32'd3} || lat !== 33) begin
            n_err++;
            $display("FAIL after_annul: got %h lat %0d want %h lat 33",
                     res, lat, {32'd0, 32'd3});
        end
    endtask

    task automatic test_overflow();
        logic [63:0] res;
        int          lat;
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
        n_cmp++;
        if (res !== {32'd0, 32'h8000_0000}) begin
            n_err++;
            $display("FAIL ovf_signed: got %h want %h",
                     res, {32'd0, 32'h8000_0000});
        end
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, res, lat);
        n_cmp++;
        if (res !== {32'd0, 32'hFFFF_FFFF}) begin
            n_err++;
            $display("FAIL divu_max_1: got %h want %h",
                     res, {32'd0, 32'hFFFF_FFFF});
        end
    endtask

    task automatic test_reset_mid();
        logic        saw_ready;
        int          lat;
        signed_div_i = 1'b1;
        opdata1_i = 32'hFFFF_F000;
        opdata2_i = 32'd17;
        start_i = 1'b1;
        saw_ready = 1'b0;
        tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ready_o) saw_ready = 1'b1;
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (saw_ready || {result_o, ready_o, busy_o} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_mid: got rdy_seen=%b res=%h rdy=%b busy=%b want 0",
                     saw_ready, result_o, ready_o, busy_o);
        end
        rst = 1'b1;
        lat = -1;
        tick();
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        n_cmp++;
        if (lat !== 33 ||
            result_o !== model(1'b1, 32'hFFFF_F000, 32'd17)) begin
            n_err++;
            $display("FAIL reset_restart: got %h lat %0d want %h lat 33",
                     result_o, lat, model(1'b1, 32'hFFFF_F000, 32'd17));
        end
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_random_back_to_back();
        logic [63:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        int          lat;
        int          want_lat;
        for (int i = 0; i < 40; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if (i == 0) a = 32'h8000_0000;
            do_op(sg, a, b, res, lat);
            want_lat = (b == 32'd0) ? 2 : 33;
            n_cmp++;
            if (res !== model(sg, a, b) || lat !== want_lat) begin
                n_err++;
                $display("FAIL rand%0d s=%b %h/%h: got %h lat %0d want %h lat %0d",
                         i, sg, a, b, res, lat, model(sg, a, b), want_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_byzero();
        test_hold_end();
        test_annul();
        test_overflow();
        test_reset_mid();
        test_random_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
